// File: rtl/decode_regfile_fwd.sv
// Y86-64 register file (15 x DATA_W) with the decode-stage operand forwarding network.
// Writes happen from the W stage on the rising edge; reads and forwarding are combinational.
module decode_regfile_fwd #(
    parameter int          DATA_W = 64,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter logic [3:0]  RSP_ID = 4'h4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        d_icode,
    input  logic [DATA_W-1:0] d_valP,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              W_valid,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic [DATA_W-1:0] rf_rsp
);
    localparam int NREGS = 15;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // M port is checked first so it wins a same-ID dual write (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (W_valid) begin
            for (int r = 0; r < NREGS; r++) begin
                if (W_dstM != RNONE && W_dstM == 4'(r))
                    regs[r] <= W_valM;
                else if (W_dstE != RNONE && W_dstE == 4'(r))
                    regs[r] <= W_valE;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (d_srcA != RNONE) rd_a = regs[d_srcA];
        if (d_srcB != RNONE) rd_b = regs[d_srcB];
    end

    // Youngest producer wins; a RNONE source has already returned zero, so
    // bubble stages (RNONE IDs) can never match below.
    always_comb begin
        fwd_a = rd_a;
        if (d_srcA == RNONE)                    fwd_a = '0;
        else if (d_srcA == e_dstE)              fwd_a = e_valE;
        else if (d_srcA == M_dstM)              fwd_a = m_valM;
        else if (d_srcA == M_dstE)              fwd_a = M_valE;
        else if (W_valid && d_srcA == W_dstM)   fwd_a = W_valM;
        else if (W_valid && d_srcA == W_dstE)   fwd_a = W_valE;
    end

    always_comb begin
        fwd_b = rd_b;
        if (d_srcB == RNONE)                    fwd_b = '0;
        else if (d_srcB == e_dstE)              fwd_b = e_valE;
        else if (d_srcB == M_dstM)              fwd_b = m_valM;
        else if (d_srcB == M_dstE)              fwd_b = M_valE;
        else if (W_valid && d_srcB == W_dstM)   fwd_b = W_valM;
        else if (W_valid && d_srcB == W_dstE)   fwd_b = W_valE;
    end

    // jXX and call carry valP through the valA slot.
    assign d_valA = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valP : fwd_a;
    assign d_valB = fwd_b;
    assign rf_rsp = regs[RSP_ID];

endmodule
